// File: rtl/sirene_ctrl.sv
// Siren burst controller: drives siren and hazard lights in ON/OFF bursts while
// the alarm is requested, with a silent cooldown after a full episode.
module sirene_ctrl #(
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned OFF_CYCLES = 2,
  parameter int unsigned MAX_BURSTS = 8,
  parameter int unsigned COOLDOWN   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       alarme,
  input  logic       ignicao,
  output logic       sirene,
  output logic       pisca,
  output logic [3:0] bursts,
  output logic       busy
);

  localparam int unsigned PW = 8;
  localparam int unsigned BW = 4;

  // Phase counter loads "cycles - 1" so a phase exits when it reads zero.
  localparam logic [PW-1:0] ON_LOAD  = PW'(ON_CYCLES - 1);
  localparam logic [PW-1:0] OFF_LOAD = PW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] CD_LOAD  = PW'(COOLDOWN - 1);
  localparam logic [BW-1:0] MAX_B    = BW'(MAX_BURSTS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2,
    ST_CDOWN = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          sirene_q, sirene_d;
  logic          pisca_q, pisca_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      burst_q  <= '0;
      sirene_q <= 1'b0;
      pisca_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      burst_q  <= burst_d;
      sirene_q <= sirene_d;
      pisca_q  <= pisca_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    burst_d = burst_q;
    pisca_d = 1'b0;

    // Ignition disarms from any state and overrides every other transition.
    if (ignicao) begin
      state_d = ST_IDLE;
      phase_d = '0;
      burst_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (alarme) begin
            state_d = ST_ON;
            phase_d = ON_LOAD;
            burst_d = BW'(1);
            pisca_d = 1'b1;
          end
        end
        ST_ON: begin
          if (phase_q == '0) begin
            if (burst_q == MAX_B) begin
              state_d = ST_CDOWN;
              phase_d = CD_LOAD;
            end else if (alarme) begin
              state_d = ST_OFF;
              phase_d = OFF_LOAD;
            end else begin
              state_d = ST_IDLE;
              phase_d = '0;
              burst_d = '0;
            end
          end else begin
            phase_d = phase_q - PW'(1);
            pisca_d = ~pisca_q;
          end
        end
        ST_OFF: begin
          if (phase_q == '0) begin
            if (alarme) begin
              state_d = ST_ON;
              phase_d = ON_LOAD;
              burst_d = burst_q + BW'(1);
              pisca_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
              phase_d = '0;
              burst_d = '0;
            end
          end else begin
            phase_d = phase_q - PW'(1);
          end
        end
        ST_CDOWN: begin
          if (phase_q == '0) begin
            state_d = ST_IDLE;
            burst_d = '0;
          end else begin
            phase_d = phase_q - PW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          phase_d = '0;
          burst_d = '0;
        end
      endcase
    end

    sirene_d = (state_d == ST_ON);
    busy_d   = (state_d != ST_IDLE);
  end

  assign sirene = sirene_q;
  assign pisca  = pisca_q;
  assign bursts = burst_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_sirene_ctrl.sv
// Directed bench for sirene_ctrl at default parameters; expected values are
// hand-derived from the burst/off/cooldown timing.
module tb_sirene_ctrl;

  logic       clock;
  logic       reset;
  logic       alarme;
  logic       ignicao;
  logic       sirene;
  logic       pisca;
  logic [3:0] bursts;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  sirene_ctrl #(
    .ON_CYCLES (4),
    .OFF_CYCLES(2),
    .MAX_BURSTS(8),
    .COOLDOWN  (16)
  ) u_dut (
    .clock  (clock),
    .reset  (reset),
    .alarme (alarme),
    .ignicao(ignicao),
    .sirene (sirene),
    .pisca  (pisca),
    .bursts (bursts),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic s, input logic p,
                           input logic [3:0] b, input logic bz);
    check({tag, ".sirene"}, 32'(sirene), 32'(s));
    check({tag, ".pisca"},  32'(pisca),  32'(p));
    check({tag, ".bursts"}, 32'(bursts), 32'(b));
    check({tag, ".busy"},   32'(busy),   32'(bz));
  endtask

  initial begin
    reset   = 1'b0;
    alarme  = 1'b1;
    ignicao = 1'b0;

    // Held in reset with alarm requested: everything stays low.
    tick();
    check_all("rst", 1'b0, 1'b0, 4'd0, 1'b0);
    reset = 1'b1;
    tick();
    check_all("rst_rel", 1'b1, 1'b1, 4'd1, 1'b1);

    // Full episode: 8 bursts of 4 high / 2 low, cooldown of 16, then re-arm.
    for (int b = 1; b <= 8; b++) begin
      for (int i = 0; i < 4; i++) begin
        check("ep.on.sirene", 32'(sirene), 32'd1);
        check("ep.on.pisca",  32'(pisca),  32'((i % 2) == 0));
        check("ep.on.bursts", 32'(bursts), 32'(b));
        tick();
      end
      if (b < 8) begin
        for (int i = 0; i < 2; i++) begin
          check_all("ep.off", 1'b0, 1'b0, 4'(b), 1'b1);
          tick();
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      check_all("ep.cd", 1'b0, 1'b0, 4'd8, 1'b1);
      tick();
    end
    check_all("ep.idle", 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    check_all("ep.rearm", 1'b1, 1'b1, 4'd1, 1'b1);

    // Ignition rises during the second ON cycle.
    tick();
    check("ign.on2", 32'(sirene), 32'd1);
    ignicao = 1'b1;
    tick();
    check_all("ign.kill", 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("ign.hold", 1'b0, 1'b0, 4'd0, 1'b0);
    end

    // Alarm and ignition rising together in IDLE.
    ignicao = 1'b0;
    alarme  = 1'b0;
    tick();
    check_all("both.pre", 1'b0, 1'b0, 4'd0, 1'b0);
    alarme  = 1'b1;
    ignicao = 1'b1;
    tick();
    check_all("both.1", 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    check_all("both.2", 1'b0, 1'b0, 4'd0, 1'b0);

    // Alarm drops in the first ON cycle: burst still runs 4 cycles, then IDLE.
    ignicao = 1'b0;
    tick();
    check_all("drop.on0", 1'b1, 1'b1, 4'd1, 1'b1);
    alarme = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("drop.on.sirene", 32'(sirene), 32'd1);
      check("drop.on.pisca",  32'(pisca),  32'((i % 2) == 0));
    end
    tick();
    check_all("drop.idle", 1'b0, 1'b0, 4'd0, 1'b0);

    // Asynchronous reset between edges during ON.
    alarme = 1'b1;
    tick();
    tick();
    check("ar.on2", 32'(sirene), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_all("ar.async", 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    check_all("ar.held", 1'b0, 1'b0, 4'd0, 1'b0);
    reset = 1'b1;
    tick();
    check_all("ar.fresh", 1'b1, 1'b1, 4'd1, 1'b1);

    // Alarm released during OFF ends the episode at the OFF exit.
    for (int i = 0; i < 4; i++) tick();
    check_all("off.enter", 1'b0, 1'b0, 4'd1, 1'b1);
    alarme = 1'b0;
    tick();
    check_all("off.2", 1'b0, 1'b0, 4'd1, 1'b1);
    tick();
    check_all("off.idle", 1'b0, 1'b0, 4'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sirene_ctrl.md
SIRENE_CTRL -- requirements
Module: sirene_ctrl

Interface
REQ-001 Parameter ON_CYCLES, default 4: clock cycles sirene stays high per burst (1..15).
REQ-002 Parameter OFF_CYCLES, default 2: clock cycles sirene stays low between bursts (1..15).
REQ-003 Parameter MAX_BURSTS, default 8: bursts per alarm episode before cooldown (1..15).
REQ-004 Parameter COOLDOWN, default 16: silent cycles after MAX_BURSTS bursts (1..255).
REQ-005 clock  input  1  single system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 alarme  input  1  alarm request level from the door/ignition alarm FSM.
REQ-008 ignicao  input  1  ignition level; 1 disarms the siren.
REQ-009 sirene  output  1  siren drive, registered.
REQ-010 pisca  output  1  hazard-light drive, registered.
REQ-011 bursts  output  4  ON phases started in the current episode, registered.
REQ-012 busy  output  1  1 in any state other than IDLE, registered.

Function
REQ-013 Single FSM with states IDLE, ON, OFF, CDOWN; one phase counter (8 bits) and one burst counter (4 bits).
REQ-014 IDLE: sirene=0, pisca=0, bursts=0; alarme=1 and ignicao=0 sampled at edge N -> ON, with sirene=1 and bursts=1 visible after edge N (one-edge latency).
REQ-015 ON: sirene=1; pisca toggles every cycle starting at 1; after exactly ON_CYCLES cycles in ON, FSM leaves ON.
REQ-016 ON exit: bursts==MAX_BURSTS -> CDOWN; else alarme==1 -> OFF; else -> IDLE.
REQ-017 Dropping alarme during ON does not cut the burst short; the ON phase always runs its full length unless ignicao or reset intervenes.
REQ-018 OFF: sirene=0, pisca=0; after exactly OFF_CYCLES cycles, alarme==1 -> ON with bursts incremented by 1; alarme==0 -> IDLE.
REQ-019 CDOWN: sirene=0, pisca=0, bursts holds MAX_BURSTS, alarme ignored; after exactly COOLDOWN cycles -> IDLE.
REQ-020 After CDOWN -> IDLE, a still-high alarme re-arms on the next edge (level-triggered, no rising edge required).
REQ-021 ignicao=1 sampled at any edge, in any state, forces IDLE on that edge (sirene=0, pisca=0, bursts=0, busy=0); priority over all other transitions.
REQ-022 alarme=1 and ignicao=1 in the same cycle in IDLE -> remain IDLE.
REQ-023 bursts never exceeds MAX_BURSTS and never wraps; phase counter reloads on every state entry.
REQ-024 busy=1 exactly when state is ON, OFF or CDOWN.

Reset
REQ-025 reset=0 asynchronously forces IDLE, sirene=0, pisca=0, bursts=0, busy=0, both counters 0, without waiting for a clock edge.
REQ-026 Reset asserted mid-burst kills sirene immediately; after release, the first rising edge with alarme=1, ignicao=0 starts a fresh episode at bursts=1.

Verification
REQ-027 reset=0 for 1 cycle with alarme=1 -> all outputs 0 during reset; release -> sirene=1, bursts=1 after the next edge.
REQ-028 Defaults, alarme held 1, ignicao=0 -> sirene pattern 4 high/2 low repeated, bursts counts 1..8, after 8th ON: 16 cycles sirene=0, busy=1, bursts=8, then IDLE for one cycle and bursts=1 on the following edge.
REQ-029 ignicao rises at cycle 2 of an ON phase -> sirene=0, bursts=0, busy=0 after that edge; stays IDLE while ignicao=1 despite alarme=1.
REQ-030 alarme falls at cycle 1 of ON -> sirene stays high 4 cycles total, then IDLE (no OFF phase), bursts=0.
REQ-031 alarme and ignicao rise together in IDLE -> sirene stays 0, busy stays 0.
REQ-032 reset=0 asserted between clock edges during ON -> sirene drops to 0 before the next edge; check pisca=0, bursts=0.
